// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state codes, lamp encodings and duration helper
package traffic_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [2:0] {
    INIT = 3'b000,
    Y2   = 3'b001,
    G2   = 3'b010,
    Y1   = 3'b011,
    G1   = 3'b100
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // A zero-length phase would never expire, so it is stretched to one tick.
  function automatic int eff_dur(input int d);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-driven phase counter with expiry and saturating hold
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          tick,
  input  logic          hold,
  input  logic [TW-1:0] dur,
  output logic [TW-1:0] cnt,
  output logic          done
);

  assign done = tick && (cnt == dur - TW'(1));

  // On a held expiry the count stays at dur-1 so the next tick expires again.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (done) begin
      if (!hold) cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - two-road light sequencer with rest-on-green
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int SIZE     = 3,
  parameter int TW       = 8,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 3,
  parameter int START_T  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            tick,
  input  logic            req1,
  input  logic            req2,
  output logic [SIZE-1:0] Q,
  output logic [TW-1:0]   cnt,
  output logic            phase_end
);

  localparam logic [TW-1:0] D_GREEN  = TW'(eff_dur(GREEN_T));
  localparam logic [TW-1:0] D_YELLOW = TW'(eff_dur(YELLOW_T));
  localparam logic [TW-1:0] D_START  = TW'(eff_dur(START_T));

  logic [TW-1:0] dur;
  logic          hold;
  logic          legal;
  logic          done;
  logic          clr;

  // Greens rest only while the opposing road has no demand.
  always_comb begin
    dur   = TW'(1);
    hold  = 1'b0;
    legal = 1'b1;
    case (Q)
      INIT: dur = D_START;
      G1: begin
        dur  = D_GREEN;
        hold = !req2;
      end
      Y1: dur = D_YELLOW;
      G2: begin
        dur  = D_GREEN;
        hold = !req1;
      end
      Y2: dur = D_YELLOW;
      default: legal = 1'b0;
    endcase
  end

  assign clr = !en || !legal;

  phase_timer #(.TW(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick),
    .hold (hold),
    .dur  (dur),
    .cnt  (cnt),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      Q         <= INIT;
      phase_end <= 1'b0;
    end else if (done && !hold) begin
      phase_end <= 1'b1;
      case (Q)
        INIT, Y2: Q <= G1;
        G1:       Q <= Y1;
        Y1:       Q <= G2;
        G2:       Q <= Y2;
        default:  Q <= INIT;
      endcase
    end else begin
      phase_end <= 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb/tb_traffic_sequencer.sv - vector table, corner sequences and random run vs reference model
module tb_traffic_sequencer;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst, en, tick, req1, req2;
  logic [2:0]    q;
  logic [TW-1:0] cnt;
  logic          phase_end;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  traffic_sequencer #(
    .SIZE(3), .TW(TW), .GREEN_T(4), .YELLOW_T(2), .START_T(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tick      (tick),
    .req1      (req1),
    .req2      (req2),
    .Q         (q),
    .cnt       (cnt),
    .phase_end (phase_end)
  );

  typedef struct {
    logic r, e, t, a, b;
    int   eq, ec, ep;
  } vec_t;

  vec_t tbl[15];

  // Reference model: position in the cycle INIT,G1,Y1,G2,Y2 plus ticks spent there.
  int m_pos, m_cnt, m_pe;
  int codes[5] = '{0, 4, 3, 2, 1};
  int durs[5]  = '{2, 4, 2, 4, 2};

  function automatic vec_t mk(input logic r, e, t, a, b, input int eq, ec, ep);
    vec_t v;
    v.r = r; v.e = e; v.t = t; v.a = a; v.b = b;
    v.eq = eq; v.ec = ec; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic chk_out(input string tag, input int eq, input int ec, input int ep);
    chk({tag, " Q"}, int'(q), eq);
    chk({tag, " cnt"}, int'(cnt), ec);
    chk({tag, " phase_end"}, int'(phase_end), ep);
  endtask

  task automatic step(input logic r, e, t, a, b);
    rst = r; en = e; tick = t; req1 = a; req2 = b;
    @(posedge clk);
    #1;
    if (r || !e) begin
      m_pos = 0; m_cnt = 0; m_pe = 0;
    end else begin
      m_pe = 0;
      if (t) begin
        if (m_cnt + 1 >= durs[m_pos]) begin
          if (!((m_pos == 1 && !b) || (m_pos == 3 && !a))) begin
            m_pos = (m_pos == 4) ? 1 : m_pos + 1;
            m_cnt = 0;
            m_pe  = 1;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tick = 1'b0; req1 = 1'b0; req2 = 1'b0;
    m_pos = 0; m_cnt = 0; m_pe = 0;

    tbl[0]  = mk(1, 1, 1, 1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 1, 1, 0, 1, 0);
    tbl[2]  = mk(0, 1, 1, 1, 1, 4, 0, 1);
    tbl[3]  = mk(0, 1, 1, 1, 1, 4, 1, 0);
    tbl[4]  = mk(0, 1, 1, 1, 1, 4, 2, 0);
    tbl[5]  = mk(0, 1, 1, 1, 1, 4, 3, 0);
    tbl[6]  = mk(0, 1, 1, 1, 1, 3, 0, 1);
    tbl[7]  = mk(0, 1, 1, 1, 1, 3, 1, 0);
    tbl[8]  = mk(0, 1, 1, 1, 1, 2, 0, 1);
    tbl[9]  = mk(0, 1, 1, 1, 1, 2, 1, 0);
    tbl[10] = mk(0, 1, 1, 1, 1, 2, 2, 0);
    tbl[11] = mk(0, 1, 1, 1, 1, 2, 3, 0);
    tbl[12] = mk(0, 1, 1, 1, 1, 1, 0, 1);
    tbl[13] = mk(0, 1, 1, 1, 1, 1, 1, 0);
    tbl[14] = mk(0, 1, 1, 1, 1, 4, 0, 1);

    // Full cycle from reset
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].a, tbl[i].b);
      chk_out($sformatf("seq[%0d]", i), tbl[i].eq, tbl[i].ec, tbl[i].ep);
    end

    // Rest on G1 without road2 demand
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0);
    chk_out("rest_entry", 4, 3, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 0);
      chk_out($sformatf("rest[%0d]", i), 4, 3, 0);
    end
    step(0, 1, 0, 1, 1);
    chk_out("rest_notick", 4, 3, 0);
    step(0, 1, 1, 1, 1);
    chk_out("rest_release", 3, 0, 1);

    // Sparse ticks: Y1 spans two tick periods
    step(1, 1, 1, 1, 1);
    run(6);
    chk_out("slow_entry", 3, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, (k % 4) == 0, 1, 1);
      if (k < 8) chk_out($sformatf("slow[%0d]", k), 3, (k >= 4) ? 1 : 0, 0);
      else       chk_out("slow_exit", 2, 0, 1);
    end

    // Enable drop in G2, then replay from INIT
    step(1, 1, 1, 1, 1);
    run(10);
    chk_out("en_pre", 2, 2, 0);
    step(0, 0, 1, 1, 1);
    chk_out("en_drop", 0, 0, 0);
    step(0, 0, 1, 1, 1);
    chk_out("en_hold", 0, 0, 0);
    for (int i = 1; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].a, tbl[i].b);
      chk_out($sformatf("replay[%0d]", i), tbl[i].eq, tbl[i].ec, tbl[i].ep);
    end

    // Reset wins over an expiring tick in Y1
    step(1, 1, 1, 1, 1);
    run(7);
    chk_out("rst_pre", 3, 1, 0);
    step(1, 1, 1, 1, 1);
    chk_out("rst_expire", 0, 0, 0);

    // Illegal state recovery
    step(1, 1, 1, 1, 1);
    run(4);
    force dut.Q = 3'b110;
    step(0, 1, 0, 1, 1);
    release dut.Q;
    step(0, 1, 0, 1, 1);
    chk("illegal Q", int'(q), 0);
    chk("illegal cnt", int'(cnt), 0);
    step(0, 1, 1, 1, 1);
    chk_out("illegal_resume0", 0, 1, 0);
    step(0, 1, 1, 1, 1);
    chk_out("illegal_resume1", 4, 0, 1);

    // Random run against the reference model
    step(1, 1, 1, 1, 1);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
      chk_out($sformatf("rand[%0d]", i), codes[m_pos], m_cnt, m_pe);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_sequencer.md
# traffic_sequencer

Sequencer for the two-road intersection. It owns the phase state register and a tick-driven phase timer, and advances the light sequence: init, road1 green, road1 yellow, road2 green, road2 yellow, repeat. Per-road vehicle requests let the active green rest until the opposing road wants service. Its `Q` output drives the existing output decoder `out`, which turns the state code into lamp patterns, `rstc` and `select`.

## Interface
- `SIZE`, 3: state code width; must be 3.
- `TW`, 8: phase timer width; must hold max(`GREEN_T`, `YELLOW_T`, `START_T`).
- `GREEN_T`, 20: green phase length, in ticks.
- `YELLOW_T`, 3: yellow phase length, in ticks.
- `START_T`, 2: dwell time in INIT after enable, in ticks.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; 0 forces INIT.
- `tick`  in  1  timebase strobe, one `clk` wide (for example a 1 Hz prescaler output).
- `req1`  in  1  road1 demand (vehicle sensor), level.
- `req2`  in  1  road2 demand, level.
- `Q`  out  SIZE  registered state code, to `out`.
- `cnt`  out  TW  current phase tick count (debug/display).
- `phase_end`  out  1  registered pulse, high in the first cycle of each new phase.

## Operation
- State codes:
  - INIT = 000 (all lamps dark)
  - Y2 = 001 (road1 red, road2 yellow)
  - G2 = 010 (road1 red, road2 green)
  - Y1 = 011 (road1 yellow, road2 red)
  - G1 = 100 (road1 green, road2 red)
- Codes 101–111 are illegal. From an illegal code, the next state is INIT and `cnt` is 0.
- Order: INIT → G1 → Y1 → G2 → Y2 → G1 → …
- Reset values: `Q`=000, `cnt`=0, `phase_end`=0. `rst` overrides every other input.
- `en`=0: next state is INIT, `cnt`=0, `phase_end`=0. The block holds there while `en` is low, and `tick` is ignored. If `en` falls in the same cycle as a phase expiry, `en` wins.
- Phase durations:
  - INIT: `START_T`
  - G1 and G2: `GREEN_T`
  - Y1 and Y2: `YELLOW_T`
  - A duration parameter of 0 is treated as 1.
- Timer:
  - With `en`=1 and `tick`=1, `cnt` increments.
  - Expiry occurs when `tick`=1 and `cnt` == dur−1.
  - On expiry, the next state is the successor, `cnt` becomes 0, and `phase_end` becomes 1.
  - Cycles without `tick` hold `cnt`.
- Rest-on-green:
  - In G1, if expiry is reached while `req2`=0, the block stays in G1. `cnt` saturates at `GREEN_T`−1 and `phase_end` stays 0.
  - The transition to Y1 happens on the first `tick` with `req2`=1.
  - G2 behaves the same way with `req1`.
  - Yellow and INIT phases are never extended.
  - Requests are sampled only at expiry; there is no latching.
- `phase_end` is high for exactly one cycle per state change. It does not pulse on en-forced entry to INIT.

## Timing
- All outputs are registered. The new `Q` appears the cycle after the expiring `tick`.
- With `tick` tied high, a phase lasts exactly dur cycles: `Q` holds the code for dur clocks.
- With a tick every N cycles, phase length is between (dur−1)·N+1 and dur·N cycles, depending on tick alignment at entry.
- After `rst` deasserts with `en`=1, G1 is first reached after `START_T` ticks.
- `en` going low gives `Q`=000 in the next cycle.

## Structure
- Shared package `traffic_pkg` holds the state-code localparams (INIT, Y2, G2, Y1, G1) and the lamp encodings: 100 red, 010 yellow, 001 green.
- One sub-module, `phase_timer`:
  - TW-bit counter with `clr`, `tick`, `dur` and `hold` inputs, and a `done` output.
  - The FSM supplies `dur` based on the current state.
- The next-state case logic and the output registers stay in `traffic_sequencer`.

## Test plan
All scenarios use `GREEN_T`=4, `YELLOW_T`=2, `START_T`=2, `tick`=1 every cycle and `req1`=`req2`=1 unless stated.

1. Release `rst`, `en`=1 → `Q` reads 000×2, 100×4, 011×2, 010×4, 001×2, then 100. `phase_end` pulses in the first cycle of each new code.
2. `req2`=0 during G1 → `Q` stays 100 past 4 cycles and `cnt` holds at 3. Raising `req2` gives `Q`=011 the cycle after the next tick, with `phase_end`=1.
3. `tick` every 4th cycle, entry aligned with a tick → Y1 lasts 8 cycles and `cnt` steps 0→1 once.
4. `en` dropped in G2 with `cnt`=2 → next cycle `Q`=000, `cnt`=0, `phase_end`=0. Re-enabling replays the scenario 1 sequence from INIT.
5. `rst` asserted in Y1 together with an expiring `tick` → next cycle `Q`=000, `cnt`=0, `phase_end`=0.
6. Force `Q`=110 for one cycle, then release → next cycle `Q`=000, `cnt`=0, and normal sequencing resumes.
